// File: rtl/booth_div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package booth_div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DIV_N = 4;
    localparam int CNT_W = $clog2(DIV_N + 1);

    // Callers sign-extend into 65 bits so the most-negative input still has an exact magnitude.
    function automatic logic [64:0] abs_u(input logic signed [64:0] v);
        return v[64] ? -v : v;
    endfunction

endpackage

// File: rtl/booth_divider_div_step.sv
// One restoring-division step: trial-subtract the divisor magnitude from the partial remainder.
module div_step #(
    parameter int N = 4
) (
    input  logic [N:0]   part,
    input  logic [N-1:0] div_b,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    assign q_bit    = (part >= {1'b0, div_b});
    // The low N bits of the difference are exact whenever the subtraction is kept.
    assign rem_next = q_bit ? (part[N-1:0] - div_b) : part[N-1:0];

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: 2N-bit dividend / N-bit divisor, truncating toward zero.
module booth_divider
    import booth_div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic           busy,
    output logic           valid,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           ovf,
    output logic           dz,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0] Q_MIN_MAG = {1'b1, {(N-1){1'b0}}};

    // Handshake: start is sampled only in IDLE; valid is a one-cycle pulse, and a start
    // seen while busy or during the valid cycle is dropped, never queued.
    state_t state, state_next;

    logic [2*N-1:0] abs_a;
    logic [N-1:0]   abs_b;
    logic [N-1:0]   rem, quo, mag_b;
    logic [CW-1:0]  cnt;
    logic           sign_q, sign_r, dz_l, pre_ovf;
    logic [N-1:0]   step_rem;
    logic           step_bit;
    logic           ovf_c;

    assign abs_a = (2*N)'(abs_u(65'($signed(A))));
    assign abs_b = N'(abs_u(65'($signed(B))));
    assign dbg_state = state;

    div_step #(.N(N)) u_step (
        .part     ({rem, quo[N-1]}),
        .div_b    (mag_b),
        .rem_next (step_rem),
        .q_bit    (step_bit)
    );

    // A negative quotient may reach magnitude 2^(N-1); a positive one may not.
    assign ovf_c = pre_ovf | (!sign_q & quo[N-1]) | (sign_q & (quo > Q_MIN_MAG));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0; quo <= '0; mag_b <= '0; cnt <= '0;
            sign_q <= 1'b0; sign_r <= 1'b0; dz_l <= 1'b0; pre_ovf <= 1'b0;
            Q <= '0; R <= '0; ovf <= 1'b0; dz <= 1'b0;
            valid <= 1'b0; busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    if (start) begin
                        rem     <= abs_a[2*N-1:N];
                        quo     <= abs_a[N-1:0];
                        mag_b   <= abs_b;
                        sign_q  <= A[2*N-1] ^ B[N-1];
                        sign_r  <= A[2*N-1];
                        dz_l    <= (B == '0);
                        pre_ovf <= (abs_a[2*N-1:N] >= abs_b);
                        cnt     <= CW'(N);
                    end
                end
                CALC: begin
                    busy <= 1'b1;
                    rem  <= step_rem;
                    quo  <= {quo[N-2:0], step_bit};
                    cnt  <= cnt - CW'(1);
                end
                DONE: begin
                    if (!valid) begin
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        dz    <= dz_l;
                        if (dz_l || ovf_c) begin
                            Q   <= '0;
                            R   <= '0;
                            ovf <= !dz_l;
                        end else begin
                            Q   <= sign_q ? -quo : quo;
                            R   <= sign_r ? -rem : rem;
                            ovf <= 1'b0;
                        end
                    end else begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
